// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, baud-rate FSM and level interrupt on the data bus.
// Define UART_PARITY_EN to add the CTRL parity_en/odd bits and a PARITY bit between DATA and STOP.
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          FIFO_AW      = 3,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        int_o
);

`ifdef UART_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        baud_div_q, baud_div_d;
  logic               tx_en_q, tx_en_d, int_en_q, int_en_d;
  logic               par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic               parity_q, parity_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               int_q, int_d;

  logic wr_en, wr_txdata, wr_status, wr_baud, wr_ctrl;
  logic fifo_empty, fifo_full, busy, pop, push, bit_end;
  logic [7:0]  head;
  logic [15:0] reload;

  assign wr_en     = ce & we;
  assign wr_txdata = wr_en & (addr[3:2] == 2'd0) & sel[0];
  assign wr_status = wr_en & (addr[3:2] == 2'd1) & sel[0];
  assign wr_baud   = wr_en & (addr[3:2] == 2'd2) & (sel[1:0] == 2'b11);
  assign wr_ctrl   = wr_en & (addr[3:2] == 2'd3) & sel[0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign busy       = (state_q != S_IDLE);
  // Pop is decided from pre-edge state, so a full FIFO can still accept a byte on a pop cycle.
  assign pop        = ~busy & tx_en_q & ~fifo_empty;
  assign push       = wr_txdata & (~fifo_full | pop);
  assign head       = fifo_mem_q[rd_ptr_q];
  assign bit_end    = (cnt_q == 16'd0);
  assign reload     = baud_div_q - 16'd1;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
    count_d    = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    overflow_d = overflow_q;
    baud_div_d = baud_div_q;
    tx_en_d    = tx_en_q;
    int_en_d   = int_en_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    int_d      = int_en_q & fifo_empty & ~busy;

    if (wr_status && data_i[3]) overflow_d = 1'b0;
    if (wr_txdata && !push)     overflow_d = 1'b1;
    if (wr_baud) baud_div_d = (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
    if (wr_ctrl) begin
      tx_en_d   = data_i[0];
      int_en_d  = data_i[1];
      par_en_d  = PARITY_EN & data_i[2];
      par_odd_d = PARITY_EN & data_i[3];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? reload : cnt_q - 16'd1;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    txd       = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (pop) begin
          shift_d   = head;
          parity_d  = PARITY_EN & (^head ^ par_odd_q);
          bit_idx_d = 3'd0;
          cnt_d     = reload;
          state_d   = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        txd = shift_q[0];
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        txd = parity_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_div_q <= BAUD_DIV_RST;
      tx_en_q    <= 1'b0;
      int_en_q   <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      parity_q   <= 1'b0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      baud_div_q <= baud_div_d;
      tx_en_q    <= tx_en_d;
      int_en_q   <= int_en_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      parity_q   <= parity_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      int_q      <= int_d;
    end
  end

  // NOTE: FIFO storage is not reset; the flushed pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= data_i[7:0];
  end

  always_comb begin
    data_o = 32'h0;
    if (ce && !we) begin
      unique case (addr[3:2])
        2'd0: data_o = 32'h0;
        2'd1: data_o = {24'h0, 4'(count_q), overflow_q, busy, fifo_empty, fifo_full};
        2'd2: data_o = {16'h0, baud_div_q};
        default: data_o = {28'h0, par_odd_q, par_en_q, int_en_q, tx_en_q};
      endcase
    end
  end

  assign int_o = int_q;

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register steps plus random bytes against a frame model.
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_BD = 32'h8, A_CT = 32'hC;

  logic        clk = 1'b0;
  logic        rst, ce, we, txd, int_o;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;

  int n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .txd(txd), .int_o(int_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
    @(negedge clk);
    ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1 d = data_o;
    ce = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // Frame model: bit period k of an 8N1 frame is start(0), data LSB first, then stop(1).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Waits for the start bit, then checks txd on every cycle of the frame and the idle gap after it.
  task automatic check_frame(input logic [7:0] b, input int baud, input int max_wait, output int waited);
    logic [31:0] st;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (txd !== 1'b0 && waited < max_wait);
    check($sformatf("start_seen[%02h]", b), {31'h0, txd}, 32'h0);
    bus_read(A_ST, st);
    check($sformatf("busy_in_frame[%02h]", b), {31'h0, st[2]}, 32'h1);
    for (int i = 0; i < 10 * baud; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("txd[%02h] bit%0d cyc%0d", b, i / baud, i % baud),
            {31'h0, txd}, {31'h0, frame_bit(b, i / baud)});
    end
    @(negedge clk);
    check($sformatf("idle_gap[%02h]", b), {31'h0, txd}, 32'h1);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    logic saw_low;
    saw_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    check(tag, {31'h0, saw_low}, 32'h0);
  endtask

  initial begin
    int          w, n, baud;
    logic [7:0]  q[$];
    logic [7:0]  b;

    ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; data_i = 32'h0; rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_txd", {31'h0, txd}, 32'h1);
    check("rst_int", {31'h0, int_o}, 32'h0);
    check("rst_data_o_idle", data_o, 32'h0);
    read_check("rst_status", A_ST, 32'h2);
    read_check("rst_ctrl", A_CT, 32'h0);
    read_check("rst_bauddiv", A_BD, 32'd434);
    read_check("rst_txdata_reads0", A_TX, 32'h0);

    // Single 0xA5 frame at 4 cycles per bit
    bus_write(A_BD, 32'd4, 4'hF);
    read_check("bauddiv_4", A_BD, 32'd4);
    bus_write(A_CT, 32'h1, 4'hF);
    bus_write(A_TX, 32'hA5, 4'hF);
    check_frame(8'hA5, 4, 4, w);
    check("a5_latency", w, 1);
    read_check("a5_done_status", A_ST, 32'h2);
    check("a5_int_disabled", {31'h0, int_o}, 32'h0);

    // Overflow with transmitter disabled
    bus_write(A_CT, 32'h0, 4'hF);
    for (int k = 1; k <= 9; k++) bus_write(A_TX, k, 4'hF);
    read_check("ovf_status", A_ST, 32'h89);
    bus_write(A_ST, 32'h8, 4'hF);
    read_check("ovf_cleared", A_ST, 32'h81);
    bus_write(A_CT, 32'h1, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      check_frame(8'(k), 4, 4, w);
      check($sformatf("gap_before_%0d", k), w, 1);
    end
    read_check("ovf_drained", A_ST, 32'h2);
    watch_idle("ovf_byte9_lost", 50);

    // Random bytes and baud rates against the queue model
    for (int r = 0; r < 3; r++) begin
      baud = $urandom_range(1, 5);
      n    = $urandom_range(1, 8);
      bus_write(A_CT, 32'h0, 4'hF);
      bus_write(A_BD, baud, 4'hF);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_write(A_TX, {24'h0, b}, 4'hF);
      end
      read_check($sformatf("rnd%0d_status", r), A_ST, (n << 4) | ((n == 8) ? 1 : 0));
      bus_write(A_CT, 32'h1, 4'hF);
      while (q.size() > 0) begin
        b = q.pop_front();
        check_frame(b, baud, 4, w);
      end
      read_check($sformatf("rnd%0d_done", r), A_ST, 32'h2);
    end

    // Interrupt: drops while a frame is pending/active, rises one cycle after STOP ends
    bus_write(A_BD, 32'd2, 4'hF);
    bus_write(A_CT, 32'h3, 4'hF);
    @(negedge clk);
    check("int_idle_high", {31'h0, int_o}, 32'h1);
    b = 8'($urandom);
    bus_write(A_TX, {24'h0, b}, 4'hF);
    check_frame(b, 2, 4, w);
    check("int_low_at_stop_end", {31'h0, int_o}, 32'h0);
    @(negedge clk);
    check("int_rises", {31'h0, int_o}, 32'h1);

    // BAUDDIV=0 stores 1: one cycle per bit
    bus_write(A_CT, 32'h1, 4'hF);
    bus_write(A_BD, 32'h0, 4'hF);
    read_check("bauddiv_zero_is_1", A_BD, 32'h1);
    bus_write(A_BD, 32'h0000_0007, 4'h1);
    read_check("bauddiv_partial_sel_ignored", A_BD, 32'h1);
    bus_write(A_TX, 32'hFF, 4'hF);
    check_frame(8'hFF, 1, 4, w);
    read_check("ff_done", A_ST, 32'h2);

    // Reset in the middle of DATA with three bytes queued
    bus_write(A_CT, 32'h0, 4'hF);
    bus_write(A_BD, 32'd4, 4'hF);
    for (int k = 0; k < 3; k++) bus_write(A_TX, $urandom_range(0, 255), 4'hF);
    bus_write(A_CT, 32'h1, 4'hF);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (txd !== 1'b0 && w < 4);
    check("mid_rst_start_seen", {31'h0, txd}, 32'h0);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_txd_high", {31'h0, txd}, 32'h1);
    read_check("mid_rst_status", A_ST, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    read_check("post_rst_status", A_ST, 32'h2);
    read_check("post_rst_ctrl", A_CT, 32'h0);
    read_check("post_rst_bauddiv", A_BD, 32'd434);
    check("post_rst_int", {31'h0, int_o}, 32'h0);
    watch_idle("post_rst_no_frames", 60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
